// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, line levels and payload width for TX and RX.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam int   DATA_BITS   = 8;
    localparam int   IDX_W       = $clog2(DATA_BITS);
endpackage

// File: rtl/baud_tick.sv
// baud_tick: bit-boundary strobe every CLKS_PER_BIT cycles, restarted by clear_i.
module baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);
    logic [15:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == 16'(CLKS_PER_BIT - 1);
    assign cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/transmitter.sv
// transmitter: UART TX serialiser (start, 8 data LSB first, stop bits); parity bit added when TX_PARITY_EN is defined.
module transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
`ifdef TX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    output logic       TXD,
    output logic       tx_busy,
    output logic       tx_done
);
    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic                   txd_q, txd_d, busy_q, busy_d, done_q, done_d;
    logic                   tick;
`ifdef TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk), .reset(reset), .clear_i(state_q == IDLE), .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (send) begin
                state_d = START;
                shift_d = data;
                idx_d   = '0;
                stop_d  = 1'b0;
`ifdef TX_PARITY_EN
                par_d   = ^data ^ PARITY_ODD;
`endif
            end
            START: if (tick) state_d = DATA;
            DATA: if (tick) begin
                if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    shift_d = shift_q >> 1;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: if (tick) begin
                if (stop_q == 1'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    stop_d  = stop_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level is registered from the next state so TXD changes exactly on bit boundaries.
`ifdef TX_PARITY_EN
        txd_d = state_d == START ? START_LEVEL : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_q : IDLE_LEVEL;
`else
        txd_d = state_d == START ? START_LEVEL : state_d == DATA ? shift_d[0] : IDLE_LEVEL;
`endif
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            txd_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TXD     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: scoreboard bench for transmitter; covers the parity build when TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_transmitter;
`ifdef TX_PARITY_EN
    localparam int NU = 3;
`else
    localparam int NU = 2;
`endif
    typedef struct {
        int         u;
        int         cpb;
        logic [7:0] d;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst  [NU];
    logic       send [NU];
    logic [7:0] data [NU];
    logic       txd  [NU];
    logic       busy [NU];
    logic       done [NU];
    logic       exp_q [$];
    vec_t       vecs [$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    transmitter #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(rst[0]), .send(send[0]), .data(data[0]),
        .TXD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );
    transmitter #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .reset(rst[1]), .send(send[1]), .data(data[1]),
        .TXD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );
`ifdef TX_PARITY_EN
    transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(rst[2]), .send(send[2]), .data(data[2]),
        .TXD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int u, input logic [7:0] d, input logic par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef TX_PARITY_EN
        exp_q.push_back(par ^ (u == 2));
`else
        if (par === 1'bx) $display("note: unknown parity entry for unit %0d", u);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Requests a frame and checks every cycle of it against the queued bit levels.
    task automatic run_frame(input int u, input logic [7:0] d, input int cpb, input bit hold);
        int   nb;
        logic e;
        data[u] = d;
        send[u] = 1'b1;
        nb = exp_q.size();
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < cpb; c++) begin
                send[u] = hold || (b == 4 && c == 0);
                data[u] = b >= 2 ? ~d : d;
                check($sformatf("u%0d d%02h bit%0d c%0d txd", u, d, b, c), txd[u], e);
                check($sformatf("u%0d d%02h bit%0d busy", u, d, b), busy[u], 1);
                check($sformatf("u%0d d%02h bit%0d done", u, d, b), done[u], 0);
                @(negedge clk);
            end
        end
        check($sformatf("u%0d d%02h idle txd", u, d), txd[u], 1);
        check($sformatf("u%0d d%02h idle busy", u, d), busy[u], 0);
        check($sformatf("u%0d d%02h done pulse", u, d), done[u], 1);
        if (!hold) begin
            @(negedge clk);
            check($sformatf("u%0d d%02h done clear", u, d), done[u], 0);
            check($sformatf("u%0d d%02h busy clear", u, d), busy[u], 0);
            check($sformatf("u%0d d%02h txd clear", u, d), txd[u], 1);
        end
    endtask

    initial begin
        logic [9:0] seq;
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b1;
            send[u] = 1'b0;
            data[u] = 8'h00;
        end
        vecs.push_back('{0, 1, 8'hA5, 1'b0});
        vecs.push_back('{1, 4, 8'h3C, 1'b0});
        vecs.push_back('{0, 1, 8'h07, 1'b1});
        vecs.push_back('{1, 4, 8'h80, 1'b1});
        vecs.push_back('{1, 4, 8'h5A, 1'b0});
        vecs.push_back('{0, 1, 8'hFF, 1'b0});
`ifdef TX_PARITY_EN
        vecs.push_back('{2, 1, 8'hA5, 1'b0});
        vecs.push_back('{2, 1, 8'h07, 1'b1});
`endif
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d reset txd", u), txd[u], 1);
            check($sformatf("u%0d reset busy", u), busy[u], 0);
            check($sformatf("u%0d reset done", u), done[u], 0);
            rst[u] = 1'b0;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                check($sformatf("u%0d idle%0d txd", u, n), txd[u], 1);
                check($sformatf("u%0d idle%0d busy", u, n), busy[u], 0);
                check($sformatf("u%0d idle%0d done", u, n), done[u], 0);
            end
        end
`ifndef TX_PARITY_EN
        seq = 10'b1101001010;
        for (int i = 0; i < 10; i++) exp_q.push_back(seq[i]);
        run_frame(0, 8'hA5, 1, 1'b0);
`else
        seq = '0;
`endif
        foreach (vecs[i]) begin
            push_frame(vecs[i].u, vecs[i].d, vecs[i].par);
            run_frame(vecs[i].u, vecs[i].d, vecs[i].cpb, 1'b0);
        end
        push_frame(0, 8'h00, 1'b0);
        run_frame(0, 8'h00, 1, 1'b1);
        push_frame(0, 8'hFF, 1'b0);
        run_frame(0, 8'hFF, 1, 1'b0);
        data[1] = 8'hA5;
        send[1] = 1'b1;
        @(negedge clk);
        send[1] = 1'b0;
        repeat (17) @(negedge clk);
        check("abort bit3 txd", txd[1], 0);
        check("abort bit3 busy", busy[1], 1);
        rst[1] = 1'b1;
        #1;
        check("abort txd", txd[1], 1);
        check("abort busy", busy[1], 0);
        check("abort done", done[1], 0);
        @(negedge clk);
        rst[1] = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check($sformatf("post abort%0d done", n), done[1], 0);
            check($sformatf("post abort%0d busy", n), busy[1], 0);
            check($sformatf("post abort%0d txd", n), txd[1], 1);
        end
        push_frame(1, 8'hC3, 1'b0);
        run_frame(1, 8'hC3, 4, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
